// File: rtl/output_port_demux.sv
// Fans lookup-annotated AXI4-Stream packets out to NUM_PORTS output streams using the tuser destination bitmap.
// Optional build macro OPD_SRC_FILTER_EN removes the ingress port from the destination set.
module output_port_demux #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 8,
  parameter int SRC_PORT_POS       = 16,
  parameter int DST_PORT_POS       = 24
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic [NUM_PORTS-1:0]            m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            m_axis_tready,
  output logic [31:0]                     fwd_count,
  output logic [31:0]                     drop_count,
  output logic [1:0]                      fsm_state
);

  // Handshake: a beat moves on a channel at a rising edge where valid and ready
  // are both high; valid never waits on ready, and data/valid hold until taken.

  typedef enum logic [1:0] {HEADER = 2'd0, PAYLOAD = 2'd1, DROP = 2'd2} state_t;

  state_t                state, state_next;
  logic [NUM_PORTS-1:0]  pending, cur_mask, dst_mask, eff_mask, pending_drain, load_mask;
  logic                  reg_free, accept, load, latch_mask, inc_fwd, inc_drop;

  assign dst_mask = s_axis_tuser[DST_PORT_POS +: NUM_PORTS];

`ifdef OPD_SRC_FILTER_EN
  logic [NUM_PORTS-1:0] src_mask;
  assign src_mask = s_axis_tuser[SRC_PORT_POS +: NUM_PORTS];
  assign eff_mask = dst_mask & ~src_mask;
`else
  assign eff_mask = dst_mask;
`endif

  // Ports still owing a handshake after this cycle; zero means the register frees now.
  assign pending_drain = pending & ~m_axis_tready;
  assign reg_free      = (pending_drain == '0);
  assign s_axis_tready = axi_resetn & ((state == DROP) | reg_free);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = pending;
  assign fsm_state     = state;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_mask  = cur_mask;
    latch_mask = 1'b0;
    inc_fwd    = 1'b0;
    inc_drop   = 1'b0;
    case (state)
      HEADER: begin
        if (accept) begin
          if (eff_mask != '0) begin
            load       = 1'b1;
            load_mask  = eff_mask;
            latch_mask = 1'b1;
            inc_fwd    = 1'b1;
            if (!s_axis_tlast) state_next = PAYLOAD;
          end else begin
            inc_drop = 1'b1;
            if (!s_axis_tlast) state_next = DROP;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          load = 1'b1;
          if (s_axis_tlast) state_next = HEADER;
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) state_next = HEADER;
      end
      default: state_next = HEADER;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) state <= HEADER;
    else             state <= state_next;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pending      <= '0;
      cur_mask     <= '0;
      m_axis_tdata <= '0;
      m_axis_tstrb <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      pending <= load ? load_mask : pending_drain;
      if (latch_mask) cur_mask <= eff_mask;
      if (load) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tstrb <= s_axis_tstrb;
        m_axis_tuser <= s_axis_tuser;
        m_axis_tlast <= s_axis_tlast;
      end
    end
  end

  // Packet counters stick at all-ones instead of wrapping.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      if (inc_fwd && (fwd_count != '1))   fwd_count  <= fwd_count + 32'd1;
      if (inc_drop && (drop_count != '1)) drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_output_port_demux.sv
// Directed bench for output_port_demux: per-port expected queues fed from the input side,
// drained by the output monitor, plus hand-computed counter and timing checks.
module tb_output_port_demux;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int NP = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   s_tdata;
  logic [DW/8-1:0] s_tstrb;
  logic [UW-1:0]   s_tuser;
  logic            s_tlast;
  logic            s_tvalid;
  logic            s_tready;
  logic [DW-1:0]   m_tdata;
  logic [DW/8-1:0] m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tlast;
  logic [NP-1:0]   m_tvalid;
  logic [NP-1:0]   m_tready;
  logic [31:0]     fwd_count;
  logic [31:0]     drop_count;
  logic [1:0]      fsm_state;

  logic [63:0]     exp_q [NP][$];
  int              assert_count = 0;
  int              error_count  = 0;
  int              last_wait;
  int              wait_n;
  bit              in_pkt;
  logic [NP-1:0]   model_mask;

  always #5 clk = ~clk;

  output_port_demux dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .fwd_count     (fwd_count),
    .drop_count    (drop_count),
    .fsm_state     (fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NP-1:0] model_eff(input logic [31:0] u);
`ifdef OPD_SRC_FILTER_EN
    return u[31:24] & ~u[23:16];
`else
    return u[31:24];
`endif
  endfunction

  // Scoreboard: outputs checked first, then the beat accepted at the coming edge is queued.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NP; i++) begin
        if (m_tvalid[i]) begin
          check($sformatf("valid_expected_p%0d", i), 64'(exp_q[i].size() != 0), 64'd1);
          if (m_tready[i] && exp_q[i].size() != 0)
            check($sformatf("beat_p%0d", i), {m_tuser[31:0], m_tdata[30:0], m_tlast},
                  exp_q[i].pop_front());
        end
      end
      if (s_tvalid && s_tready) begin
        if (!in_pkt) model_mask = model_eff(s_tuser[31:0]);
        for (int i = 0; i < NP; i++)
          if (model_mask[i]) exp_q[i].push_back({s_tuser[31:0], s_tdata[30:0], s_tlast});
        in_pkt = !s_tlast;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NP; i++) exp_q[i].delete();
    in_pkt     = 1'b0;
    model_mask = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [31:0] u, input logic last);
    int n = 0;
    s_tdata  = {224'd0, d};
    s_tuser  = {96'd0, u};
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    last_wait = n;
    if (n >= 200) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] dst, input logic [7:0] src, input logic [15:0] tag,
                          input int nbeats);
    for (int b = 0; b < nbeats; b++)
      send_beat({tag, 16'(b)}, {dst, src, tag}, b == nbeats - 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '1;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = '1;
    clear_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tready", s_tready, 0);
    check("rst_fwd", fwd_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_state", fsm_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tready", s_tready, 1);
    @(posedge clk);
    #1;

    // Unicast, 4 beats to port 2
    send_beat(32'h0001_0000, {8'h04, 8'h00, 16'h0001}, 1'b0);
    check("uc_latency", m_tvalid, 8'h04);
    for (int b = 1; b < 4; b++) begin
      send_beat({16'h0001, 16'(b)}, {8'h04, 8'h00, 16'h0001}, b == 3);
      check("uc_throughput", last_wait, 0);
    end
    idle(3);
    check("uc_fwd", fwd_count, 1);
    check("uc_state", fsm_state, 0);

    // Multicast to ports 0,2,4 with port 4 held off for 3 cycles
    fork
      send_pkt(8'h15, 8'h00, 16'h0002, 2);
      begin
        m_tready = 8'hEF;
        wait_n   = 0;
        @(negedge clk);
        while (m_tvalid == '0 && wait_n < 20) begin
          wait_n++;
          @(negedge clk);
        end
        check("mc_first", m_tvalid, 8'h15);
        check("mc_stall_tready", s_tready, 0);
        repeat (2) begin
          @(negedge clk);
          check("mc_hold", m_tvalid, 8'h10);
          check("mc_hold_tready", s_tready, 0);
        end
        @(posedge clk);
        #1;
        m_tready = '1;
      end
    join
    idle(3);
    check("mc_fwd", fwd_count, 2);

    // Empty destination set, 5 beats discarded
    for (int b = 0; b < 5; b++) begin
      send_beat({16'h0003, 16'(b)}, {8'h00, 8'h00, 16'h0003}, b == 4);
      check("drop_tready", last_wait, 0);
    end
    idle(2);
    check("drop_count", drop_count, 1);
    check("drop_state", fsm_state, 0);
    send_pkt(8'h08, 8'h00, 16'h0004, 2);
    idle(3);
    check("after_drop_fwd", fwd_count, 3);

    // Back-to-back single-beat packets
    for (int k = 0; k < 4; k++) begin
      send_beat({16'h0005, 16'(k)}, {8'(1 << k), 8'h00, 16'h0005}, 1'b1);
      check("b2b_throughput", last_wait, 0);
    end
    check("b2b_last_port", m_tvalid, 8'h08);
    idle(3);
    check("b2b_fwd", fwd_count, 7);
    check("b2b_state", fsm_state, 0);

    // Source-port filtering
    send_pkt(8'h03, 8'h02, 16'h0006, 1);
    send_pkt(8'h02, 8'h02, 16'h0007, 1);
    idle(3);
`ifdef OPD_SRC_FILTER_EN
    check("filter_fwd", fwd_count, 8);
    check("filter_drop", drop_count, 2);
`else
    check("filter_fwd", fwd_count, 9);
    check("filter_drop", drop_count, 1);
`endif

    // Reset in the middle of a packet with the output stalled
    m_tready = '0;
    send_beat(32'h0008_0000, {8'h04, 8'h00, 16'h0008}, 1'b0);
    s_tdata  = {224'd0, 32'h0008_0001};
    s_tvalid = 1'b1;
    @(posedge clk);
    #3;
    check("mid_pending", m_tvalid, 8'h04);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tready", s_tready, 0);
    check("mid_rst_fwd", fwd_count, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_state", fsm_state, 0);
    s_tvalid = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = '1;
    send_pkt(8'h02, 8'h00, 16'h0009, 1);
    idle(3);
    check("post_mid_fwd", fwd_count, 1);
    check("post_mid_drop", drop_count, 0);

    idle(2);
    for (int i = 0; i < NP; i++)
      check($sformatf("queue_empty_p%0d", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, error_count);
    $finish;
  end

endmodule
